// File: rtl/aes_pkg.sv
// Shared AES definitions: sequencer FSM states, key-size tables, block width
// and the byte-level round primitives used by the round and schedule modules.
package aes_pkg;

  localparam int BLK_W  = 128;
  localparam int MAX_NR = 14;
  localparam int FULLKEY_MAX_W = BLK_W * (MAX_NR + 1);

  localparam int NR_128 = 10;
  localparam int NK_128 = 4;
  localparam int NR_192 = 12;
  localparam int NK_192 = 6;
  localparam int NR_256 = 14;
  localparam int NK_256 = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Round count for a key width; 0 flags an unsupported width.
  function automatic int nr_for_key(input int n);
    case (n)
      128:     return NR_128;
      192:     return NR_192;
      256:     return NR_256;
      default: return 0;
    endcase
  endfunction

  function automatic int nk_for_key(input int n);
    case (n)
      128:     return NK_128;
      192:     return NK_192;
      256:     return NK_256;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254, 0 maps to 0) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte k of the block sits at bits [127-8k -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[BLK_W-1-8*i -: 8] = sbox(s[BLK_W-1-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[BLK_W-1-8*(4*c+rw) -: 8] = s[BLK_W-1-8*(4*((c+rw)%4)+rw) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[BLK_W-1-32*c    -: 8];
      a1 = s[BLK_W-1-32*c-8  -: 8];
      a2 = s[BLK_W-1-32*c-16 -: 8];
      a3 = s[BLK_W-1-32*c-24 -: 8];
      r[BLK_W-1-32*c    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[BLK_W-1-32*c-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[BLK_W-1-32*c-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[BLK_W-1-32*c-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] add_round_key(input logic [BLK_W-1:0] s,
                                                     input logic [BLK_W-1:0] k);
    return s ^ k;
  endfunction

  // Round key i out of the expanded schedule; round key 0 is the most significant slice.
  function automatic logic [BLK_W-1:0] rk_slice(input logic [FULLKEY_MAX_W-1:0] fullkeys,
                                                input int i, input int nr);
    return fullkeys[BLK_W*(nr+1)-1-BLK_W*i -: BLK_W];
  endfunction

endpackage

// File: rtl/aes_final_round.sv
// Last AES round: subBytes, shiftRows, addRoundKey; the final round has no mixColumns.
module aes_final_round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] round_key,
  output logic [BLK_W-1:0] state_out
);

  assign state_out = add_round_key(shift_rows(sub_bytes(state)), round_key);

endmodule

// File: rtl/encryptRound.sv
// One full AES round: subBytes, shiftRows, mixColumns, addRoundKey.
module encryptRound
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] round_key,
  output logic [BLK_W-1:0] state_out
);

  assign state_out = add_round_key(mix_columns(shift_rows(sub_bytes(state))), round_key);

endmodule

// File: rtl/keyExpansion.sv
// Full AES key schedule, computed combinationally: Nr+1 round keys packed with
// round key 0 in the most significant 128 bits.
module keyExpansion
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic [N-1:0]             key,
  output logic [BLK_W*(Nr+1)-1:0]  fullkeys
);

  localparam int NW = 4 * (Nr + 1);

  // Word-serial recurrence unrolled into one combinational cone.
  always_comb begin
    logic [31:0] w [NW];
    logic [31:0] temp;
    logic [7:0]  rcon;
    fullkeys = '0;
    rcon     = 8'h01;
    temp     = '0;
    for (int i = 0; i < Nk; i++) begin
      w[i] = key[N-1-32*i -: 32];
    end
    for (int i = Nk; i < NW; i++) begin
      temp = w[i-1];
      if (i % Nk == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end else if (Nk > 6 && i % Nk == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i-Nk] ^ temp;
    end
    for (int i = 0; i < NW; i++) begin
      fullkeys[BLK_W*(Nr+1)-1-32*i -: 32] = w[i];
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption: one round datapath reused per clock, sequenced by
// an IDLE/RUN/FINAL/DONE FSM with valid/ready on both sides.
// Optional block counter (blocks_done, clr_cnt) enabled by AES_SEQ_PERF_CNT_EN.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_block,
  input  logic [N-1:0]     in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_block,
  output logic             busy
`ifdef AES_SEQ_PERF_CNT_EN
  ,
  input  logic             clr_cnt,
  output logic [31:0]      blocks_done
`endif
);

  localparam int  CNT_W = $clog2(Nr + 1);
  localparam int  FK_W  = BLK_W * (Nr + 1);
  localparam bit  PARAMS_OK = (nr_for_key(N) != 0) && (Nr == nr_for_key(N)) &&
                              (Nk == nk_for_key(N));

  if (!PARAMS_OK) begin : g_bad_params
    $error("aes_round_sequencer: illegal (N,Nr,Nk) tuple");
  end

  seq_state_t         fsm_reg, fsm_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [N-1:0]       key_reg, key_next;
  logic [BLK_W-1:0]   state_reg, state_next;

  logic [N-1:0]             sched_key;
  logic [FK_W-1:0]          fullkeys;
  logic [FULLKEY_MAX_W-1:0] fullkeys_ext;
  int                       rk_idx;
  logic [BLK_W-1:0]         round_key;
  logic [BLK_W-1:0]         round_out;
  logic [BLK_W-1:0]         final_out;

  // In IDLE the schedule runs on the offered key so rk[0] is ready in the accept cycle.
  assign sched_key = (fsm_reg == IDLE) ? in_key : key_reg;

  keyExpansion #(.N(N), .Nr(Nr), .Nk(Nk)) u_key_expansion (
    .key      (sched_key),
    .fullkeys (fullkeys)
  );

  // Widen the schedule to the package's fixed slice-function width.
  always_comb begin
    fullkeys_ext = '0;
    fullkeys_ext[FK_W-1:0] = fullkeys;
  end

  // Round-key index: 0 at accept, the counter while running, Nr for the last round.
  always_comb begin
    case (fsm_reg)
      IDLE:    rk_idx = 0;
      FINAL:   rk_idx = Nr;
      default: rk_idx = int'(cnt_reg);
    endcase
    round_key = rk_slice(fullkeys_ext, rk_idx, Nr);
  end

  encryptRound u_round (
    .state     (state_reg),
    .round_key (round_key),
    .state_out (round_out)
  );

  aes_final_round u_final_round (
    .state     (state_reg),
    .round_key (round_key),
    .state_out (final_out)
  );

  // State register: FSM, round counter, held key and cipher state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg   <= IDLE;
      cnt_reg   <= '0;
      key_reg   <= '0;
      state_reg <= '0;
    end else begin
      fsm_reg   <= fsm_next;
      cnt_reg   <= cnt_next;
      key_reg   <= key_next;
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    fsm_next   = fsm_reg;
    cnt_next   = cnt_reg;
    key_next   = key_reg;
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_block  = '0;
    busy       = 1'b0;
    case (fsm_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          key_next   = in_key;
          state_next = add_round_key(in_block, round_key);
          cnt_next   = CNT_W'(1);
          fsm_next   = RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        state_next = round_out;
        cnt_next   = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(Nr - 1)) fsm_next = FINAL;
      end
      FINAL: begin
        busy       = 1'b1;
        state_next = final_out;
        fsm_next   = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_block = state_reg;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

`ifdef AES_SEQ_PERF_CNT_EN
  logic [31:0] perf_reg;

  // Completed-block counter; a clear wins over a coincident handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_reg <= '0;
    end else if (clr_cnt) begin
      perf_reg <= '0;
    end else if (out_valid && out_ready) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end

  assign blocks_done = perf_reg;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: three instances (AES-128/192/256)
// share handshake inputs; AES-128 results go through a scoreboard queue.
module tb_aes_round_sequencer;

  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [191:0] K_192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic [191:0] key192;
  logic [255:0] key256;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_block;
  logic         in_ready192, out_valid192, busy192;
  logic [127:0] out_block192;
  logic         in_ready256, out_valid256, busy256;
  logic [127:0] out_block256;
`ifdef AES_SEQ_PERF_CNT_EN
  logic         clr_cnt;
  logic [31:0]  blocks_done, blocks_done192, blocks_done256;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] sb_q[$];

  always #5 clk = ~clk;

  aes_round_sequencer #(.N(128), .Nr(10), .Nk(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy)
`ifdef AES_SEQ_PERF_CNT_EN
    , .clr_cnt(clr_cnt), .blocks_done(blocks_done)
`endif
  );

  aes_round_sequencer #(.N(192), .Nr(12), .Nk(6)) dut192 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready192),
    .in_block(in_block), .in_key(key192), .out_valid(out_valid192),
    .out_ready(out_ready), .out_block(out_block192), .busy(busy192)
`ifdef AES_SEQ_PERF_CNT_EN
    , .clr_cnt(clr_cnt), .blocks_done(blocks_done192)
`endif
  );

  aes_round_sequencer #(.N(256), .Nr(14), .Nk(8)) dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready256),
    .in_block(in_block), .in_key(key256), .out_valid(out_valid256),
    .out_ready(out_ready), .out_block(out_block256), .busy(busy256)
`ifdef AES_SEQ_PERF_CNT_EN
    , .clr_cnt(clr_cnt), .blocks_done(blocks_done256)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Compare the presented ciphertext with the oldest expected entry.
  task automatic pop_compare(input string tag);
    check({tag, "_sb_nonempty"}, 128'(sb_q.size() != 0), 128'd1);
    if (sb_q.size() != 0) check(tag, out_block, sb_q.pop_front());
  endtask

  // One AES-128 transaction: offer, accept, latency, optional back-pressure, handshake.
  task automatic do_block(input logic [127:0] blk, input logic [127:0] key,
                          input logic [127:0] exp, input int hold, input bit scramble,
                          input bit clr_at_hs, input string tag);
    int t;
    int lat;
    logic [127:0] snap;
    in_block  = blk;
    in_key    = key;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    t = 0;
    while (!in_ready && t < 40) begin
      tick();
      t++;
    end
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    tick();
    sb_q.push_back(exp);
    in_valid = scramble;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == 0) begin
        check({tag, "_busy"}, 128'(busy), 128'd1);
        check({tag, "_in_ready_low"}, 128'(in_ready), 128'd0);
      end
      if (scramble) begin
        in_block = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 128'(lat), 128'd10);
    snap = out_block;
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
      check({tag, "_hold_block"}, out_block, snap);
      check({tag, "_hold_in_ready"}, 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
`ifdef AES_SEQ_PERF_CNT_EN
    clr_cnt = clr_at_hs;
`endif
    pop_compare({tag, "_out_block"});
    tick();
`ifdef AES_SEQ_PERF_CNT_EN
    clr_cnt = 1'b0;
`endif
    check({tag, "_valid_drop"}, 128'(out_valid), 128'd0);
    check({tag, "_back_idle"}, 128'(in_ready), 128'd1);
    $display("txn %s: block=%h key=%h out=%h latency=%0d", tag, blk, key, snap, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat128, lat192, lat256;
    logic [127:0] blk128, blk192, blk256;
    int n_acc, prev, t, pulses;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_block = '0; in_key = '0; key192 = '0; key256 = '0;
`ifdef AES_SEQ_PERF_CNT_EN
    clr_cnt = 1'b0;
`endif
    tick();
    tick();
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_block", out_block, 128'd0);
`ifdef AES_SEQ_PERF_CNT_EN
    check("rst_blocks_done", 128'(blocks_done), 128'd0);
`endif
    rst_n = 1'b1;
    tick();

    // C.1 plaintext on all three key sizes at once.
    in_block = PT_C1; in_key = K_C1; key192 = K_192; key256 = K_256;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat128 = 0; lat192 = 0; lat256 = 0;
    blk128 = '0; blk192 = '0; blk256 = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) begin
        check("k192_busy", 128'(busy192), 128'd1);
        check("k256_in_ready_low", 128'(in_ready256), 128'd0);
      end
      tick();
      if (out_valid && lat128 == 0) begin lat128 = c; blk128 = out_block; end
      if (out_valid192 && lat192 == 0) begin lat192 = c; blk192 = out_block192; end
      if (out_valid256 && lat256 == 0) begin lat256 = c; blk256 = out_block256; end
    end
    check("c1_128_latency", 128'(lat128), 128'd10);
    check("c1_128_block", blk128, CT_C1);
    check("c1_192_latency", 128'(lat192), 128'd12);
    check("c1_192_block", blk192, CT_192);
    check("c1_256_latency", 128'(lat256), 128'd14);
    check("c1_256_block", blk256, CT_256);
    check("k256_idle_after", 128'(in_ready256), 128'd1);
    $display("txn multi: out128=%h@%0d out192=%h@%0d out256=%h@%0d",
             blk128, lat128, blk192, lat192, blk256, lat256);

    do_block(PT_B, K_B, CT_B, 5, 1'b0, 1'b0, "fips_b_hold");
    do_block(PT_C1, K_C1, CT_C1, 0, 1'b1, 1'b0, "c1_scramble");

    // Continuous offer with out_ready high: accepts every Nr+2 clocks.
    in_block = PT_C1; in_key = K_C1; in_valid = 1'b1; out_ready = 1'b1;
    n_acc = 0; prev = -1;
    for (int cyc = 0; cyc < 41; cyc++) begin
      if (in_valid && in_ready) begin
        sb_q.push_back(CT_C1);
        if (prev >= 0) check("stream_spacing", 128'(cyc - prev), 128'd12);
        $display("txn stream: accept at cycle %0d", cyc);
        prev = cyc;
        n_acc++;
      end
      if (out_valid) pop_compare("stream_out");
      tick();
    end
    in_valid = 1'b0;
    t = 0;
    while (sb_q.size() != 0 && t < 30) begin
      if (out_valid) pop_compare("stream_drain");
      tick();
      t++;
    end
    check("stream_accepts", 128'(n_acc), 128'd4);
    check("stream_sb_empty", 128'(sb_q.size()), 128'd0);

    // Reset in the middle of a block.
    in_block = PT_B; in_key = K_B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("midrst_busy_before", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_out_block", out_block, 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      if (out_valid) pulses++;
      tick();
    end
    check("midrst_no_pulse", 128'(pulses), 128'd0);
    $display("txn midrst: block discarded, out_valid pulses=%0d", pulses);
    do_block(PT_C1, K_C1, CT_C1, 0, 1'b0, 1'b0, "after_rst");

`ifdef AES_SEQ_PERF_CNT_EN
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("perf_cleared", 128'(blocks_done), 128'd0);
    do_block(PT_C1, K_C1, CT_C1, 0, 1'b0, 1'b0, "perf1");
    do_block(PT_B, K_B, CT_B, 0, 1'b0, 1'b0, "perf2");
    do_block(PT_C1, K_C1, CT_C1, 0, 1'b0, 1'b0, "perf3");
    check("perf_three", 128'(blocks_done), 128'd3);
    do_block(PT_B, K_B, CT_B, 0, 1'b0, 1'b1, "perf4_clr");
    check("perf_clr_priority", 128'(blocks_done), 128'd0);
    do_block(PT_C1, K_C1, CT_C1, 0, 1'b0, 1'b0, "perf5");
    check("perf_resume", 128'(blocks_done), 128'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
